// File: rtl/datapath_pkg.sv
// Shared types for the sequenced datapath: opcodes, sequencer states, iteration count.
// Latency: none (declarations only).
// Backpressure: not applicable.
package datapath_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SHR  = 4'd4,
      OP_SHRA = 4'd5,
      OP_SHL  = 4'd6,
      OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,
      OP_MUL  = 4'd9,
      OP_DIV  = 4'd10,
      OP_NEG  = 4'd11,
      OP_NOT  = 4'd12
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T3,
      S_T4,
      S_ITER,
      S_T5,
      S_DONE
   } state_t;

   // Iterative MUL/DIV spends one cycle per result bit.
   localparam int WIDTH_DEFAULT = 32;
   localparam int ITER_CYCLES   = WIDTH_DEFAULT;

   function automatic int iter_cycles(input int width);
      return width;
   endfunction

   // Opcodes 13..15 are not assigned.
   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_NOT;
   endfunction

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_datapath_if.sv
// Command/observation bus of the sequenced datapath.
// Latency: none (wires only).
// Backpressure: start is only honoured while busy=0 and done=0.
// master: drives start/op/ra/rb/rc, load port and rd_sel; slave: returns rd_data, hi, lo, busy, done, err.
interface seq_datapath_if #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
);
   localparam int RW = $clog2(NREGS);

   logic             start;
   logic [3:0]       op;
   logic [RW-1:0]    ra;
   logic [RW-1:0]    rb;
   logic [RW-1:0]    rc;
   logic             ld_en;
   logic [RW-1:0]    ld_sel;
   logic [WIDTH-1:0] ld_data;
   logic [RW-1:0]    rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
      input  rd_data, hi, lo, busy, done, err
   );

   modport slave (
      input  start, op, ra, rb, rc, ld_en, ld_sel, ld_data, rd_sel,
      output rd_data, hi, lo, busy, done, err
   );

endinterface

// File: rtl/iter_muldiv.sv
// Signed shift-add multiply / restoring divide on operand magnitudes, one bit per cycle.
// Latency: operands captured on go; result valid combinationally in the WIDTH-th cycle after go.
// Backpressure: none; the caller counts cycles and samples result at the right one.
// Ports: clk, clr (sync active-low), go, is_div, a, b in; result[2W-1:0], div0 out.
module iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               go,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               div0
);

   // acc_q: partial product high half / partial remainder.
   // qr_q : multiplier being shifted out / quotient being shifted in.
   logic [WIDTH-1:0] acc_q, qr_q, mag_b_q;
   logic             div_q, neg_a_q, neg_b_q, div0_q;

   logic [WIDTH:0]     sum, rs;
   logic [WIDTH-1:0]   diff, nxt_acc, nxt_qr, q_s, r_s;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   always_comb begin
      sum = {1'b0, acc_q} + {1'b0, (qr_q[0] ? mag_b_q : {WIDTH{1'b0}})};
      rs  = {acc_q, qr_q[WIDTH-1]};
      // Low bits are exact whenever rs >= divisor, the only case they are used.
      diff = rs[WIDTH-1:0] - mag_b_q;
      if (div_q) begin
         if (rs >= {1'b0, mag_b_q}) begin
            nxt_acc = diff;
            nxt_qr  = {qr_q[WIDTH-2:0], 1'b1};
         end else begin
            nxt_acc = rs[WIDTH-1:0];
            nxt_qr  = {qr_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         nxt_acc = sum[WIDTH:1];
         nxt_qr  = {sum[0], qr_q[WIDTH-1:1]};
      end

      // Result reflects the step taking place this cycle, so it is final
      // in the last iteration cycle rather than one cycle later.
      prod = {nxt_acc, nxt_qr};
      // A zero divisor leaves the dividend magnitude in the remainder, so
      // the sign-fixed remainder equals the dividend; only the quotient is forced.
      q_s = div0_q ? {WIDTH{1'b1}} : ((neg_a_q ^ neg_b_q) ? -nxt_qr : nxt_qr);
      r_s = neg_a_q ? -nxt_acc : nxt_acc;
      if (div_q) result = {r_s, q_s};
      else       result = (neg_a_q ^ neg_b_q) ? -prod : prod;
   end

   assign div0 = div0_q;

   always_ff @(posedge clk) begin
      if (!clr) begin
         acc_q   <= '0;
         qr_q    <= '0;
         mag_b_q <= '0;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         div0_q  <= 1'b0;
      end else if (go) begin
         acc_q   <= '0;
         qr_q    <= mag(a);
         mag_b_q <= mag(b);
         div_q   <= is_div;
         neg_a_q <= a[WIDTH-1];
         neg_b_q <= b[WIDTH-1];
         div0_q  <= is_div && (b == '0);
      end else begin
         acc_q <= nxt_acc;
         qr_q  <= nxt_qr;
      end
   end

endmodule

// File: rtl/seq_datapath.sv
// Register file + ALU driven by an internal T-step sequencer, one instruction per start.
// Latency: ALU ops done in cycle 4, MUL/DIV in cycle WIDTH+3, illegal op in cycle 1.
// Backpressure: start and ld_en are ignored outside IDLE; busy flags the window.
// Ports: clk, clr (sync active-low), bus (slave): start/op/ra/rb/rc, ld_*, rd_sel in; rd_data, hi, lo, busy, done, err out.
module seq_datapath
   import datapath_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic           clk,
   input  logic           clr,
   seq_datapath_if.slave  bus
);

   localparam int RW    = $clog2(NREGS);
   localparam int SW    = $clog2(WIDTH);
   localparam int ITERS = iter_cycles(WIDTH);

   logic [WIDTH-1:0]   regs [NREGS];
   state_t             state;
   logic [3:0]         op_q;
   logic [RW-1:0]      ra_q, rb_q, rc_q;
   logic [WIDTH-1:0]   y_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] z_q;
   logic [SW-1:0]      cnt_q;
   logic               busy_q, done_q, err_q;

   logic [WIDTH-1:0]   alu, opb;
   logic [SW-1:0]      sh;
   logic [2*WIDTH-1:0] md_result;
   logic               md_div0, md_go, md_is_div;

   assign bus.rd_data = regs[bus.rd_sel];
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

   always_comb begin
      opb = regs[rc_q];
      sh  = opb[SW-1:0];
      alu = '0;
      case (op_q)
         OP_ADD:  alu = y_q + opb;
         OP_SUB:  alu = y_q - opb;
         OP_AND:  alu = y_q & opb;
         OP_OR:   alu = y_q | opb;
         OP_SHR:  alu = y_q >> sh;
         OP_SHRA: alu = $signed(y_q) >>> sh;
         OP_SHL:  alu = y_q << sh;
         OP_ROR:  alu = (y_q >> sh) | (y_q << (WIDTH - int'(sh)));
         OP_ROL:  alu = (y_q << sh) | (y_q >> (WIDTH - int'(sh)));
         OP_NEG:  alu = -y_q;
         OP_NOT:  alu = ~y_q;
         default: alu = '0;
      endcase
   end

   // Operands are handed over in T3, the same cycle Y is latched.
   assign md_go     = (state == S_T3) && is_muldiv(op_q);
   assign md_is_div = (op_q == OP_DIV);

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .clr    (clr),
      .go     (md_go),
      .is_div (md_is_div),
      .a      (regs[rb_q]),
      .b      (regs[rc_q]),
      .result (md_result),
      .div0   (md_div0)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= S_IDLE;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         y_q    <= '0;
         z_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // A load in the start cycle commits before T3 reads the file.
               if (bus.ld_en) regs[bus.ld_sel] <= bus.ld_data;
               if (bus.start) begin
                  op_q  <= bus.op;
                  ra_q  <= bus.ra;
                  rb_q  <= bus.rb;
                  rc_q  <= bus.rc;
                  err_q <= 1'b0;
                  if (is_legal(bus.op)) begin
                     state  <= S_T3;
                     busy_q <= 1'b1;
                  end else begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end
               end
            end
            S_T3: begin
               y_q   <= regs[rb_q];
               cnt_q <= SW'(ITERS - 1);
               state <= is_muldiv(op_q) ? S_ITER : S_T4;
            end
            S_T4: begin
               z_q   <= {{WIDTH{1'b0}}, alu};
               state <= S_T5;
            end
            S_ITER: begin
               if (cnt_q == '0) begin
                  z_q   <= md_result;
                  state <= S_T5;
                  if (md_div0) err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_T5: begin
               if (is_muldiv(op_q)) begin
                  hi_q <= z_q[2*WIDTH-1:WIDTH];
                  lo_q <= z_q[WIDTH-1:0];
               end else begin
                  regs[ra_q] <= z_q[WIDTH-1:0];
               end
               state  <= S_DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            S_DONE: state <= S_IDLE;
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed-vector bench for seq_datapath: ALU table, MUL/DIV table, corner sequences.
// Latency: checks done cycle per instruction class.
// Backpressure: drives start only from IDLE; exercises loads while busy.
module tb_seq_datapath;
   import datapath_pkg::*;

   localparam int W = 32;
   localparam int N = 16;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   seq_datapath_if #(.WIDTH(W), .NREGS(N)) bus ();

   seq_datapath #(.WIDTH(W), .NREGS(N)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        err;
   } md_vec_t;

   alu_vec_t alu_v [15];
   md_vec_t  md_v  [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [3:0] sel, input logic [31:0] v);
      @(negedge clk);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = sel;
      bus.ld_data = v;
      @(negedge clk);
      bus.ld_en   = 1'b0;
   endtask

   task automatic read_reg(input logic [3:0] sel, output logic [31:0] v);
      bus.rd_sel = sel;
      #1;
      v = bus.rd_data;
   endtask

   // Issues one instruction; ld_cyc (-1 = none) raises ld_en in that cycle.
   task automatic exec(input string name, input logic [3:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc, input int ld_cyc,
                       input logic [3:0] ld_sel, input logic [31:0] ld_dat, input int exp_lat);
      int lat;
      int bcnt;
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.ra      = ra;
      bus.rb      = rb;
      bus.rc      = rc;
      bus.ld_sel  = ld_sel;
      bus.ld_data = ld_dat;
      bus.ld_en   = (ld_cyc == 0);
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.ld_en = (c == ld_cyc);
         if (bus.done) begin
            lat = c;
            break;
         end
         if (bus.busy) bcnt++;
      end
      bus.ld_en = 1'b0;
      check({name, "_done_cycle"}, lat, exp_lat);
      check({name, "_busy_cycles"}, bcnt, (exp_lat == 1) ? 0 : exp_lat - 1);
      check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      int seen;

      alu_v[0]  = '{OP_ADD,  32'h0000_0007, 32'h0000_0005, 32'h0000_000C};
      alu_v[1]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      alu_v[2]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
      alu_v[3]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
      alu_v[4]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
      alu_v[5]  = '{OP_SHR,  32'h8000_0010, 32'h0000_0004, 32'h0800_0001};
      alu_v[6]  = '{OP_SHRA, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001};
      alu_v[7]  = '{OP_SHL,  32'h8000_0010, 32'h0000_0004, 32'h0000_0100};
      alu_v[8]  = '{OP_SHL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
      alu_v[9]  = '{OP_ROR,  32'h1234_5678, 32'h0000_0008, 32'h7812_3456};
      alu_v[10] = '{OP_ROR,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
      alu_v[11] = '{OP_ROL,  32'h1234_5678, 32'h0000_0004, 32'h2345_6781};
      alu_v[12] = '{OP_NEG,  32'h0000_0005, 32'h0000_0009, 32'hFFFF_FFFB};
      alu_v[13] = '{OP_NEG,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
      alu_v[14] = '{OP_NOT,  32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0};

      md_v[0] = '{OP_MUL, 32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFD_0000, 1'b0};
      md_v[1] = '{OP_MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
      md_v[2] = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      md_v[3] = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      md_v[4] = '{OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      md_v[5] = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

      bus.start = 1'b0; bus.op = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
      bus.ld_en = 1'b0; bus.ld_sel = '0; bus.ld_data = '0; bus.rd_sel = '0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_err",  {31'd0, bus.err},  32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      clr = 1'b1;
      read_reg(4'd5, r);
      check("rst_r5", r, 32'd0);

      for (int i = 0; i < 15; i++) begin
         load(4'd2, alu_v[i].a);
         load(4'd3, alu_v[i].b);
         exec($sformatf("alu%0d", i), alu_v[i].op, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 4);
         read_reg(4'd1, r);
         check($sformatf("alu%0d_r1", i), r, alu_v[i].exp);
      end

      load(4'd2, 32'd9);
      exec("alias", OP_ADD, 4'd2, 4'd2, 4'd2, -1, 4'd0, 32'd0, 4);
      read_reg(4'd2, r);
      check("alias_r2", r, 32'd18);

      for (int i = 0; i < 6; i++) begin
         load(4'd6, md_v[i].a);
         load(4'd7, md_v[i].b);
         exec($sformatf("md%0d", i), md_v[i].op, 4'd0, 4'd6, 4'd7, -1, 4'd0, 32'd0, W + 3);
         check($sformatf("md%0d_hi", i), bus.hi, md_v[i].hi);
         check($sformatf("md%0d_lo", i), bus.lo, md_v[i].lo);
         check($sformatf("md%0d_err", i), {31'd0, bus.err}, {31'd0, md_v[i].err});
      end
      read_reg(4'd0, r);
      check("md_r0_untouched", r, 32'd0);

      repeat (3) @(negedge clk);
      check("err_sticky", {31'd0, bus.err}, 32'd1);
      load(4'd2, 32'd1);
      load(4'd3, 32'd2);
      exec("err_clear", OP_ADD, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 4);
      check("err_clear_err", {31'd0, bus.err}, 32'd0);

      exec("illegal", 4'd14, 4'd1, 4'd2, 4'd3, -1, 4'd0, 32'd0, 1);
      check("illegal_err", {31'd0, bus.err}, 32'd1);
      read_reg(4'd1, r);
      check("illegal_r1", r, 32'd3);

      load(4'd2, 32'd7);
      load(4'd3, 32'd5);
      exec("ld_busy", OP_ADD, 4'd1, 4'd2, 4'd3, 2, 4'd3, 32'd100, 4);
      read_reg(4'd1, r);
      check("ld_busy_r1", r, 32'd12);
      read_reg(4'd3, r);
      check("ld_busy_r3", r, 32'd5);

      exec("ld_start", OP_ADD, 4'd1, 4'd2, 4'd3, 0, 4'd2, 32'd100, 4);
      read_reg(4'd1, r);
      check("ld_start_r1", r, 32'd105);

      // Reset asserted in cycle 10 of a MUL.
      load(4'd4, 32'hFFFF_FFFD);
      load(4'd5, 32'h0001_0000);
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MUL; bus.ra = 4'd0; bus.rb = 4'd4; bus.rc = 4'd5;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (c == 10) begin
            check("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
            clr = 1'b0;
         end
      end
      @(negedge clk);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.done}, 32'd0);
      check("midrst_err",  {31'd0, bus.err},  32'd0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);
      read_reg(4'd4, r);
      check("midrst_r4", r, 32'd0);
      clr  = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      check("midrst_quiet", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
